// File: rtl/ita_package.sv
// Shared ITA output-buffer types and default sizing constants.
// OutbufDepth/OutbufSlack replace the old FifoDepth at integration.
package ita_package;

   localparam int unsigned OutbufN     = 16;
   localparam int unsigned OutbufWi    = 8;
   localparam int unsigned OutbufDepth = 14;
   localparam int unsigned OutbufSlack = 10;
   localparam int unsigned OutbufSplit = 1;

   typedef logic [$clog2(OutbufDepth+1)-1:0]         outbuf_usage_t;
   typedef logic [OutbufN*OutbufWi-1:0]             outbuf_row_t;
   typedef logic [OutbufN*OutbufWi/OutbufSplit-1:0] outbuf_beat_t;

   typedef enum logic {
      BEAT_IDLE   = 1'b0,
      BEAT_STREAM = 1'b1
   } beat_state_e;

   // Index width that stays legal for a single-entry range.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ita_outbuf_serializer.sv
// Splits the head row into OUT_SPLIT beats on a valid/ready port and
// signals pop back to storage when the last beat is accepted.
module ita_outbuf_serializer
   import ita_package::*;
#(
   parameter int unsigned N         = OutbufN,
   parameter int unsigned WI        = OutbufWi,
   parameter int unsigned OUT_SPLIT = OutbufSplit
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  logic [N*WI-1:0]           row_i,
   input  logic                      avail_next_i,
   input  logic                      ready_i,
   output logic                      valid_o,
   output logic [N*WI/OUT_SPLIT-1:0] oup_o,
   output logic                      pop_o,
   output beat_state_e               state_o
);

   localparam int unsigned BW  = N * WI / OUT_SPLIT;
   localparam int unsigned BCW = idx_width(OUT_SPLIT);
   localparam logic [BCW-1:0] LastBeat = BCW'(OUT_SPLIT - 1);

   // Handshake: a beat transfers on a cycle with valid_o && ready_i; once
   // valid_o is high it and oup_o hold until that transfer happens.
   beat_state_e    state_q;
   logic [BCW-1:0] beat_q;
   logic [BW-1:0]  beat_data;
   logic           hs;

   assign valid_o = (state_q == BEAT_STREAM);
   assign hs      = valid_o && ready_i;
   assign pop_o   = hs && (beat_q == LastBeat);
   assign state_o = state_q;

   always_comb begin
      beat_data = '0;
      for (int k = 0; k < int'(OUT_SPLIT); k++) begin
         if (beat_q == BCW'(k)) beat_data = row_i[k*BW +: BW];
      end
   end

   assign oup_o = valid_o ? beat_data : '0;

   // avail_next_i looks at next-cycle usage so a push into an empty
   // buffer is presented one cycle later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BEAT_IDLE;
         beat_q  <= '0;
      end else if (clear_i) begin
         state_q <= BEAT_IDLE;
         beat_q  <= '0;
      end else begin
         case (state_q)
            BEAT_IDLE: begin
               if (avail_next_i) state_q <= BEAT_STREAM;
            end
            BEAT_STREAM: begin
               if (pop_o) begin
                  beat_q  <= '0;
                  state_q <= avail_next_i ? BEAT_STREAM : BEAT_IDLE;
               end else if (hs) begin
                  beat_q <= beat_q + BCW'(1);
               end
            end
            default: state_q <= BEAT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ita_output_buffer.sv
// Circular row buffer with beat serializer and early back-pressure for ITA.
// Define ITA_OUTBUF_MONITOR_EN to build the usage high-water-mark monitor.
module ita_output_buffer
   import ita_package::*;
#(
   parameter int unsigned N         = OutbufN,
   parameter int unsigned WI        = OutbufWi,
   parameter int unsigned DEPTH     = OutbufDepth,
   parameter int unsigned OUT_SPLIT = OutbufSplit,
   parameter int unsigned SLACK     = OutbufSlack
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic                           push_i,
   input  logic [N*WI-1:0]                data_i,
   output logic                           almost_full_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic                           overflow_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [N*WI/OUT_SPLIT-1:0]      oup_o,
   output logic [$clog2(DEPTH+1)-1:0]     usage_o,
   output logic [$clog2(DEPTH+1)-1:0]     usage_max_o
);

   localparam int unsigned UW = $clog2(DEPTH + 1);
   localparam int unsigned PW = idx_width(DEPTH);
   localparam logic [UW-1:0] DepthU  = UW'(DEPTH);
   localparam logic [UW-1:0] SlackU  = UW'(SLACK);
   localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

   logic [N*WI-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [UW-1:0]   usage_q, usage_d;
   logic            overflow_q;
   logic            full, pop, push_acc;
   beat_state_e     beat_state;

   assign full     = (usage_q == DepthU);
   // A full buffer still takes a push when the head row leaves this cycle.
   assign push_acc = push_i && (!full || pop);

   always_comb begin
      usage_d = usage_q;
      if (clear_i)              usage_d = '0;
      else if (push_acc && !pop) usage_d = usage_q + UW'(1);
      else if (!push_acc && pop) usage_d = usage_q - UW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         usage_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clear_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         usage_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         usage_q <= usage_d;
         if (push_acc) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
         if (pop)      rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
         if (push_i && !push_acc) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_acc && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   ita_outbuf_serializer #(
      .N         (N),
      .WI        (WI),
      .OUT_SPLIT (OUT_SPLIT)
   ) i_serializer (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .row_i        (mem_q[rd_ptr_q]),
      .avail_next_i (usage_d != '0),
      .ready_i      (ready_i),
      .valid_o      (valid_o),
      .oup_o        (oup_o),
      .pop_o        (pop),
      .state_o      (beat_state)
   );

   assign full_o        = full;
   assign empty_o       = (usage_q == '0) && (beat_state == BEAT_IDLE);
   assign overflow_o    = overflow_q;
   assign usage_o       = usage_q;
   assign almost_full_o = ((DepthU - usage_q) <= SlackU);

`ifdef ITA_OUTBUF_MONITOR_EN
   logic [UW-1:0] usage_max_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   usage_max_q <= '0;
      else if (clear_i)              usage_max_q <= '0;
      else if (full)                 usage_max_q <= DepthU;
      else if (usage_q > usage_max_q) usage_max_q <= usage_q;
   end

   assign usage_max_o = usage_max_q;

`ifndef SYNTHESIS
   logic report_armed_q;

   // Reports once per clear, when the buffer first drains back to empty.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      report_armed_q <= 1'b1;
      else if (clear_i) report_armed_q <= 1'b1;
      else if (report_armed_q && (usage_q != '0) && (usage_d == '0)) begin
         $display("ita_output_buffer: usage high-water mark %0d of %0d",
                  (usage_q > usage_max_q) ? usage_q : usage_max_q, DEPTH);
         report_armed_q <= 1'b0;
      end
   end
`endif
`else
   assign usage_max_o = '0;
`endif

endmodule

// File: doc/ita_output_buffer.md
# ita_output_buffer

Parametrised output staging block for the ITA datapath. It sits between the activation stage and the external output handshake, and replaces the fixed FIFO and output-controller pair with one block. The block accepts one row of `N` requantised lanes per push and buffers up to `DEPTH` rows. It emits each row as `OUT_SPLIT` narrower beats on a valid/ready interface. It gives the controller early back-pressure (`almost_full_o`), sized to cover the pipeline latency between issue and push.

## Interface
Parameters:
- `N`, 16: lanes per row.
- `WI`, 8: bits per lane.
- `DEPTH`, 14: row capacity. Must be ≥ 2.
- `OUT_SPLIT`, 1: beats per row. Must divide `N`. Output width is `N*WI/OUT_SPLIT`.
- `SLACK`, 10: `almost_full_o` asserts when free rows ≤ `SLACK`. Must be < `DEPTH`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `clear_i`, in, 1: synchronous flush.
- `push_i`, in, 1: row valid from the activation stage. There is no ready; the pusher never stalls.
- `data_i`, in, `N*WI`: row, lane 0 in the LSBs.
- `almost_full_o`, out, 1: stop-issue hint to the controller.
- `full_o`, out, 1: usage == `DEPTH`.
- `empty_o`, out, 1: usage == 0 and no beat pending.
- `overflow_o`, out, 1: sticky; set by a dropped push.
- `valid_o`, out, 1: output beat valid.
- `ready_i`, in, 1: output beat accepted.
- `oup_o`, out, `N*WI/OUT_SPLIT`: beat data. Forced to 0 when `valid_o` = 0.
- `usage_o`, out, `$clog2(DEPTH+1)`: rows held.
- `usage_max_o`, out, `$clog2(DEPTH+1)`: high-water mark.

## Operation
- Storage is a circular buffer of `DEPTH` rows with write and read pointers. Both pointers wrap from `DEPTH-1` to 0, and `DEPTH` need not be a power of two.
- Push handling:
  - Push accepted: when usage < `DEPTH`, or when usage == `DEPTH` and the final beat of the head row is accepted in the same cycle.
  - Push rejected: otherwise. The row is dropped, storage is unchanged, and `overflow_o` is set until reset or `clear_i`.
- Serializer:
  - The head row is emitted as `OUT_SPLIT` beats, lane 0 first. Beat k carries lanes `k*N/OUT_SPLIT` through `(k+1)*N/OUT_SPLIT-1`.
  - A beat counter advances on `valid_o && ready_i`.
  - Only acceptance of beat `OUT_SPLIT-1` pops the row and resets the counter to 0.
- Beat state machine:
  - IDLE: `valid_o` = 0. Moves to STREAM when usage > 0.
  - STREAM: `valid_o` = 1. On a final-beat handshake, stays in STREAM if usage after the pop is > 0, otherwise returns to IDLE.
- Once `valid_o` is high, `oup_o` holds stable until accepted (AXI-style: `valid_o` never drops without a handshake).
- Usage update: usage += push_accepted − pop. A simultaneous push and pop leaves usage unchanged.
- `almost_full_o` = (`DEPTH` − usage) ≤ `SLACK`. It is combinational from the registered usage.
- `clear_i`: pointers, usage, beat counter, `overflow_o` and `usage_max_o` return to 0 at the next edge. A push or pop in that same cycle is ignored. Takes priority over every other event.
- Reset mid-stream: behaves the same as `clear_i`, but asynchronous. In-flight rows are lost.

## Timing
- Reset values: `valid_o` 0, `oup_o` 0, `full_o` 0, `almost_full_o` 0 (1 if `SLACK` ≥ `DEPTH`, which is illegal), `empty_o` 1, `overflow_o` 0, `usage_o` 0, `usage_max_o` 0.
- Latency: a push in cycle c into an empty buffer gives `valid_o` = 1 in cycle c+1 (registered storage, no fall-through).
- Throughput:
  - `OUT_SPLIT` = 1 with `ready_i` held high: one row per cycle sustained.
  - General case: one row per `OUT_SPLIT` cycles.
- `usage_o`, `full_o`, `empty_o` and `almost_full_o` reflect state after the previous edge.

## Configuration
- `ITA_OUTBUF_MONITOR_EN` defined: `usage_max_o` registers max(`usage_max_o`, usage) every cycle. It is set to `DEPTH` whenever `full_o` is high, and cleared by `clear_i`. A simulation-only `$display` reports the high-water mark on the falling edge of `usage_o`'s non-zero span following `clear_i`.
- Undefined: `usage_max_o` is tied to 0 and no monitor logic is built.

## Structure
- Shared package (`ita_package`) holds:
  - `outbuf_usage_t`
  - `outbuf_row_t` (`N*WI`)
  - `outbuf_beat_t`
  - default constants `OutbufDepth` and `OutbufSlack`, replacing `FifoDepth` at integration.
- One sub-module, `ita_outbuf_serializer`: the beat counter, lane select, valid/ready logic, zero-forcing of `oup_o`, and the `pop` output back to storage.
- The storage and pointer logic stays in the top module.

## Test plan
- `DEPTH`=4, `OUT_SPLIT`=1, `ready_i`=1: push rows 0x01…04 on consecutive cycles → `valid_o` rises the cycle after the first push; `oup_o` = 01, 02, 03, 04 on consecutive cycles; `usage_o` never exceeds 1.
- `ready_i`=0, push 5 rows with `DEPTH`=4 → `full_o`=1 after the 4th push; 5th row dropped; `overflow_o`=1; then `ready_i`=1 drains exactly 4 rows in order.
- `OUT_SPLIT`=2, `N`=4, `WI`=8, row 0x44332211 → beats 0x2211 then 0x4433; `ready_i` toggling 1,0,1 → the second beat is held stable during the stall.
- `DEPTH`=4, usage 4, push coinciding with final-beat acceptance → push accepted; `usage_o` stays 4; `overflow_o` stays 0.
- `SLACK`=2, `DEPTH`=4: `almost_full_o` = 0 at usage 1 and 1 at usage 2; `clear_i` at usage 3 mid-beat → next cycle usage 0, `valid_o` 0, `oup_o` 0, `overflow_o` 0.
- With `ITA_OUTBUF_MONITOR_EN`: fill to 3, then drain → `usage_max_o` = 3; after `clear_i` → 0. Without the macro → `usage_max_o` is 0 throughout.
